// File: rtl/colisao_placar.sv
// colisao_placar: once per video frame, checks ball/rectangle overlaps and keeps
// score, lives, invulnerability window and game-over state for the VGA overlay.
module colisao_placar #(
  parameter int VIDAS_INICIAIS    = 3,
  parameter int PONTOS_POR_ACERTO = 1,
  parameter int PONTOS_MAX        = 999,
  parameter int INV_QUADROS       = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       quadro,
  input  logic       pausa,
  input  logic       reiniciar,
  input  logic [9:0] x_bola_aliada,
  input  logic [9:0] y_bola_aliada,
  input  logic [9:0] raio_bola_aliada,
  input  logic [9:0] x_bola_inimiga,
  input  logic [9:0] y_bola_inimiga,
  input  logic [9:0] raio_bola_inimiga,
  input  logic [9:0] x_nave,
  input  logic [9:0] y_nave,
  input  logic [9:0] largura_nave,
  input  logic [9:0] altura_nave,
  input  logic [9:0] x_inimigo,
  input  logic [9:0] y_inimigo,
  input  logic [9:0] largura_inimigo,
  input  logic [9:0] altura_inimigo,
  output logic       bateu_aliada,
  output logic       nave_atingida,
  output logic [9:0] pontos,
  output logic [1:0] vidas,
  output logic       invulneravel,
  output logic       fim_de_jogo,
  output logic       reiniciarJogo
);

  localparam logic [1:0] JOGANDO  = 2'd0;
  localparam logic [1:0] AVALIA   = 2'd1;
  localparam logic [1:0] ATUALIZA = 2'd2;
  localparam logic [1:0] FIM      = 2'd3;

  localparam int INV_W = (INV_QUADROS < 2) ? 1 : $clog2(INV_QUADROS + 1);

  logic [1:0]       estado;
  logic [INV_W-1:0] contador;
  logic             prev_aliada;
  logic             prev_inimiga;

  logic [9:0] xa_p0, ya_p0, ra_p0;
  logic [9:0] xi_p0, yi_p0, ri_p0;
  logic [9:0] xn_p0, yn_p0, wn_p0, hn_p0;
  logic [9:0] xe_p0, ye_p0, we_p0, he_p0;
  logic       acerto_aliada_p1;
  logic       acerto_inimiga_p1;

  logic             novo_aliada;
  logic             perde_vida;
  logic [9:0]       pontos_prox;
  logic [1:0]       vidas_prox;
  logic [INV_W-1:0] contador_prox;

  // Ball bounding box against rectangle, widened by one bit so right/bottom edges near 1023 do not wrap.
  function automatic logic sobrepoe(input logic [9:0] xb, input logic [9:0] yb,
                                    input logic [9:0] r,  input logic [9:0] xr,
                                    input logic [9:0] yr, input logic [9:0] w,
                                    input logic [9:0] h);
    logic [10:0] xb_e, yb_e, r_e, xr_e, yr_e, w_e, h_e;
    xb_e = {1'b0, xb};
    yb_e = {1'b0, yb};
    r_e  = {1'b0, r};
    xr_e = {1'b0, xr};
    yr_e = {1'b0, yr};
    w_e  = {1'b0, w};
    h_e  = {1'b0, h};
    return ((xb_e + r_e) >= xr_e) && ((xr_e + w_e + r_e) > xb_e) &&
           ((yb_e + r_e) >= yr_e) && ((yr_e + h_e + r_e) > yb_e);
  endfunction

  function automatic logic [9:0] satura_pontos(input logic [10:0] soma);
    return (soma > 11'(PONTOS_MAX)) ? 10'(PONTOS_MAX) : soma[9:0];
  endfunction

  // Stage p0: geometry snapshot taken at the frame pulse.
  always_ff @(posedge CLOCK_50) begin
    if (estado == JOGANDO && quadro && !pausa) begin
      xa_p0 <= x_bola_aliada;
      ya_p0 <= y_bola_aliada;
      ra_p0 <= raio_bola_aliada;
      xi_p0 <= x_bola_inimiga;
      yi_p0 <= y_bola_inimiga;
      ri_p0 <= raio_bola_inimiga;
      xn_p0 <= x_nave;
      yn_p0 <= y_nave;
      wn_p0 <= largura_nave;
      hn_p0 <= altura_nave;
      xe_p0 <= x_inimigo;
      ye_p0 <= y_inimigo;
      we_p0 <= largura_inimigo;
      he_p0 <= altura_inimigo;
    end
    // Stage p1: registered overlap flags.
    if (estado == AVALIA) begin
      acerto_aliada_p1  <= sobrepoe(xa_p0, ya_p0, ra_p0, xe_p0, ye_p0, we_p0, he_p0);
      acerto_inimiga_p1 <= sobrepoe(xi_p0, yi_p0, ri_p0, xn_p0, yn_p0, wn_p0, hn_p0);
    end
  end

  always_comb begin
    novo_aliada   = acerto_aliada_p1 && !prev_aliada;
    perde_vida    = acerto_inimiga_p1 && !prev_inimiga && (contador == '0);
    pontos_prox   = pontos;
    vidas_prox    = vidas;
    contador_prox = contador;
    if (novo_aliada)
      pontos_prox = satura_pontos({1'b0, pontos} + 11'(PONTOS_POR_ACERTO));
    if (perde_vida) begin
      vidas_prox    = vidas - 2'd1;
      contador_prox = INV_W'(INV_QUADROS);
    end else if (contador != '0) begin
      contador_prox = contador - INV_W'(1);
    end
  end

  // Stage p2: effects applied to the game state.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      estado        <= JOGANDO;
      pontos        <= '0;
      vidas         <= 2'(VIDAS_INICIAIS);
      contador      <= '0;
      invulneravel  <= 1'b0;
      fim_de_jogo   <= 1'b0;
      prev_aliada   <= 1'b0;
      prev_inimiga  <= 1'b0;
      bateu_aliada  <= 1'b0;
      nave_atingida <= 1'b0;
      reiniciarJogo <= 1'b0;
    end else begin
      bateu_aliada  <= 1'b0;
      nave_atingida <= 1'b0;
      reiniciarJogo <= 1'b0;
      case (estado)
        JOGANDO: begin
          if (quadro && !pausa)
            estado <= AVALIA;
        end
        AVALIA: estado <= ATUALIZA;
        ATUALIZA: begin
          pontos        <= pontos_prox;
          vidas         <= vidas_prox;
          contador      <= contador_prox;
          invulneravel  <= (contador_prox != '0);
          prev_aliada   <= acerto_aliada_p1;
          prev_inimiga  <= acerto_inimiga_p1;
          bateu_aliada  <= novo_aliada;
          nave_atingida <= perde_vida;
          if (vidas_prox == 2'd0) begin
            estado      <= FIM;
            fim_de_jogo <= 1'b1;
          end else begin
            estado <= JOGANDO;
          end
        end
        default: begin
          // Edge history is cleared so the first frame after restart can score.
          if (reiniciar) begin
            pontos        <= '0;
            vidas         <= 2'(VIDAS_INICIAIS);
            contador      <= '0;
            invulneravel  <= 1'b0;
            prev_aliada   <= 1'b0;
            prev_inimiga  <= 1'b0;
            fim_de_jogo   <= 1'b0;
            reiniciarJogo <= 1'b1;
            estado        <= JOGANDO;
          end
        end
      endcase
    end
  end

endmodule
